// File: rtl/week5_enc_pkg.sv
// Shared types and helpers for the week-5 one-hot encoder.
// The PRIORITY_ENCODE_EN macro is consumed by week5_onehot_enc_core.
package week5_enc_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int N_DEFAULT = 4;

  // Widest word onehot_check understands; narrower words are zero-extended by the caller.
  localparam int MAX_N = 64;

  function automatic logic onehot_check(input logic [MAX_N-1:0] vec);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (vec[i]) ones++;
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/week5_onehot_enc_core.sv
// Combinational N->W one-hot encoder with error flag.
// PRIORITY_ENCODE_EN: multi-hot words encode their highest set bit instead of erroring.
module week5_onehot_enc_core
  import week5_enc_pkg::*;
#(
  parameter int N = N_DEFAULT,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] onehot,
  output logic [W-1:0] bin,
  output logic         err
);

  logic [MAX_N-1:0] onehot_ext;
  logic [W-1:0]     high_idx;
  logic             is_onehot;
  logic             any_set;

  always_comb begin
    onehot_ext = '0;
    onehot_ext[N-1:0] = onehot;
    is_onehot = onehot_check(onehot_ext);
    any_set = |onehot;
    high_idx = '0;
    // Ascending scan so the last hit, i.e. the highest set bit, wins.
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) high_idx = W'(i);
    end
  end

`ifdef PRIORITY_ENCODE_EN
  assign bin = high_idx;
  assign err = !any_set;
`else
  assign bin = is_onehot ? high_idx : '0;
  assign err = !is_onehot;
`endif

endmodule

// File: rtl/week5_ex3_encoder_sync.sv
// Registered one-hot-to-binary encoder with valid/ready on both sides and a good-word counter.
// Multi-hot handling is selected by the PRIORITY_ENCODE_EN macro (see week5_onehot_enc_core).
module week5_ex3_encoder_sync
  import week5_enc_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int CNT_W = 8,
  localparam int W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_onehot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_bin,
  output logic             out_err,
  output logic [CNT_W-1:0] good_count
);

  state_t           state_q, state_d;
  logic [W-1:0]     bin_q, bin_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [W-1:0]     enc_bin;
  logic             enc_err;
  logic             accept;

  week5_onehot_enc_core #(.N(N)) u_core (
    .onehot (in_onehot),
    .bin    (enc_bin),
    .err    (enc_err)
  );

  // A full register can still take a word in the same cycle the consumer drains it.
  assign in_ready = (state_q == EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    err_d   = err_q;
    count_d = count_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      bin_d = enc_bin;
      err_d = enc_err;
      if (!enc_err) count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      bin_q   <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign out_bin    = bin_q;
  assign out_err    = err_q;
  assign good_count = count_q;

endmodule

// File: tb/tb_week5_ex3_encoder_sync.sv
// Directed self-checking bench for week5_ex3_encoder_sync (N=4), with a second CNT_W=2 instance
// sharing the same stimulus to exercise counter wrap.
module tb_week5_ex3_encoder_sync;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_onehot;
  logic       out_ready;

  logic       in_ready, out_valid, out_err;
  logic [1:0] out_bin;
  logic [7:0] good_count;

  logic       in_ready2, out_valid2, out_err2;
  logic [1:0] out_bin2;
  logic [1:0] good_count2;

  int checks;
  int pass_count;
  int fail_count;

  week5_ex3_encoder_sync #(.N(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_onehot  (in_onehot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bin    (out_bin),
    .out_err    (out_err),
    .good_count (good_count)
  );

  week5_ex3_encoder_sync #(.N(4), .CNT_W(2)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready2),
    .in_onehot  (in_onehot),
    .out_valid  (out_valid2),
    .out_ready  (out_ready),
    .out_bin    (out_bin2),
    .out_err    (out_err2),
    .good_count (good_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic [3:0] word, input logic ready);
    in_valid  = valid;
    in_onehot = word;
    out_ready = ready;
  endtask

  // Advance one rising edge and settle 1ns past it before anything is sampled.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic valid, input logic [1:0] bin,
                          input logic err, input logic [7:0] cnt);
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(valid));
    checkOutput({tag, ".out_bin"}, 32'(out_bin), 32'(bin));
    checkOutput({tag, ".out_err"}, 32'(out_err), 32'(err));
    checkOutput({tag, ".good_count"}, 32'(good_count), 32'(cnt));
  endtask

  initial begin
    checks = 0;
    pass_count = 0;
    fail_count = 0;

    // Reset
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'b0000, 1'b0);
    stepClock();
    stepClock();
    rst_n = 1'b1;
    checkAll("reset", 1'b0, 2'd0, 1'b0, 8'd0);
    checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset.good_count2", 32'(good_count2), 32'd0);

    // Streaming, one word per cycle
    applyStimulus(1'b1, 4'b0001, 1'b1);
    stepClock();
    checkAll("stream0", 1'b1, 2'd0, 1'b0, 8'd1);
    applyStimulus(1'b1, 4'b0010, 1'b1);
    stepClock();
    checkAll("stream1", 1'b1, 2'd1, 1'b0, 8'd2);
    applyStimulus(1'b1, 4'b0100, 1'b1);
    stepClock();
    checkAll("stream2", 1'b1, 2'd2, 1'b0, 8'd3);
    applyStimulus(1'b1, 4'b1000, 1'b1);
    stepClock();
    checkAll("stream3", 1'b1, 2'd3, 1'b0, 8'd4);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    stepClock();
    checkAll("drain", 1'b0, 2'd3, 1'b0, 8'd4);

    // Consumer stall
    applyStimulus(1'b1, 4'b0100, 1'b0);
    stepClock();
    checkAll("stall.load", 1'b1, 2'd2, 1'b0, 8'd5);
    applyStimulus(1'b1, 4'b0001, 1'b0);
    #1;
    checkOutput("stall.in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      stepClock();
      checkAll("stall.hold", 1'b1, 2'd2, 1'b0, 8'd5);
      checkOutput("stall.hold.in_ready", 32'(in_ready), 32'd0);
    end
    applyStimulus(1'b1, 4'b0001, 1'b1);
    #1;
    checkOutput("release.in_ready", 32'(in_ready), 32'd1);
    stepClock();
    checkAll("release", 1'b1, 2'd0, 1'b0, 8'd6);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    stepClock();

    // All-zero word
    applyStimulus(1'b1, 4'b0000, 1'b1);
    stepClock();
    checkAll("zero", 1'b1, 2'd0, 1'b1, 8'd6);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    stepClock();

    // Multi-hot word
    applyStimulus(1'b1, 4'b0110, 1'b1);
    stepClock();
`ifdef PRIORITY_ENCODE_EN
    checkAll("multihot", 1'b1, 2'd2, 1'b0, 8'd7);
`else
    checkAll("multihot", 1'b1, 2'd0, 1'b1, 8'd6);
`endif

    // X on the data bus while not valid is ignored
    applyStimulus(1'b0, 4'bxxxx, 1'b1);
    stepClock();
    stepClock();
`ifdef PRIORITY_ENCODE_EN
    checkAll("idle_x", 1'b0, 2'd2, 1'b0, 8'd7);
`else
    checkAll("idle_x", 1'b0, 2'd0, 1'b1, 8'd6);
`endif

    // Reset while full and stalled
    applyStimulus(1'b1, 4'b1000, 1'b0);
    stepClock();
    checkOutput("prereset.out_bin", 32'(out_bin), 32'd3);
    checkOutput("prereset.out_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    rst_n = 1'b0;
    stepClock();
    rst_n = 1'b1;
    checkAll("midreset", 1'b0, 2'd0, 1'b0, 8'd0);
    checkOutput("midreset.in_ready", 32'(in_ready), 32'd1);
    checkOutput("midreset.good_count2", 32'(good_count2), 32'd0);

    // Counter wrap on the CNT_W=2 instance
    applyStimulus(1'b1, 4'b0001, 1'b1);
    stepClock();
    checkOutput("wrap.c1", 32'(good_count2), 32'd1);
    applyStimulus(1'b1, 4'b0010, 1'b1);
    stepClock();
    checkOutput("wrap.c2", 32'(good_count2), 32'd2);
    applyStimulus(1'b1, 4'b0100, 1'b1);
    stepClock();
    checkOutput("wrap.c3", 32'(good_count2), 32'd3);
    applyStimulus(1'b1, 4'b1000, 1'b1);
    stepClock();
    checkOutput("wrap.c0", 32'(good_count2), 32'd0);
    checkOutput("wrap.bin2", 32'(out_bin2), 32'd3);
    applyStimulus(1'b1, 4'b0001, 1'b1);
    stepClock();
    checkOutput("wrap.c1b", 32'(good_count2), 32'd1);
    checkAll("wrap.main", 1'b1, 2'd0, 1'b0, 8'd5);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    stepClock();
    checkOutput("final.out_valid", 32'(out_valid), 32'd0);
    checkOutput("final.out_valid2", 32'(out_valid2), 32'd0);

    $display("%0d/%0d checks passed", pass_count, checks);
    $finish;
  end

endmodule
